// File: rtl/mfdfa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mfdfa_pkg
// Purpose  : Shared constants and phase encoding for the MFDFA pipeline.
// Revision : 1.0
// ============================================================================
package mfdfa_pkg;

  localparam int FRAC_BITS  = 16;
  localparam int DEFAULT_DW = 32;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MEAN = 2'd1,
    EMIT = 2'd2
  } phase_e;

endpackage
`default_nettype wire

// File: rtl/price_buf.sv
`default_nettype none
// ============================================================================
// Module   : price_buf
// Purpose  : N x DW sample store, synchronous write, combinational read.
// Revision : 1.0
// ============================================================================
module price_buf #(
  parameter int LOG2_N = 8,
  parameter int DW     = 32
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [LOG2_N-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [LOG2_N-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  // No reset: every window overwrites all entries before they are read.
  logic [DW-1:0] mem_q [2**LOG2_N];

  always_ff @(posedge Clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/price_profile.sv
`default_nettype none
// ============================================================================
// Module   : price_profile
// Purpose  : Buffers a window of N prices, then streams the mean-removed
//            cumulative profile Y(i) one value per cycle.
// Revision : 1.0
// ============================================================================
module price_profile
  import mfdfa_pkg::*;
#(
  parameter int LOG2_N = 8,
  parameter int DW     = DEFAULT_DW,
  parameter int PW     = DW + LOG2_N + 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  output logic          out_last,
  output logic [DW-1:0] mean,
  output logic          busy
);

  localparam int                N        = 1 << LOG2_N;
  localparam int                SW       = DW + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

  phase_e                   state_q, state_d;
  logic [LOG2_N-1:0]        wr_idx_q, wr_idx_d;
  logic [LOG2_N-1:0]        rd_idx_q, rd_idx_d;
  logic [SW-1:0]            sum_q, sum_d;
  logic [DW-1:0]            mean_q, mean_d;
  logic signed [PW-1:0]     y_q, y_d;
  logic                     ov_q, ov_d;
  logic                     ol_q, ol_d;

  logic                     in_hs;
  logic                     out_hs;
  logic [LOG2_N-1:0]        raddr;
  logic [DW-1:0]            rdata;
  logic signed [DW:0]       dev;
  logic signed [PW-1:0]     dev_ext;

  assign in_ready = Rst & (state_q == LOAD);
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = ov_q & out_ready;
  assign busy     = (state_q == MEAN) | (state_q == EMIT);

  // During MEAN the fresh mean is used so Y(0) can be formed on the same edge.
  assign mean_d  = (state_q == MEAN) ? sum_q[SW-1:LOG2_N] : mean_q;
  assign raddr   = (state_q == EMIT) ? rd_idx_q : '0;
  assign dev     = $signed({1'b0, rdata}) - $signed({1'b0, mean_d});
  assign dev_ext = {{(PW-DW-1){dev[DW]}}, dev};

  price_buf #(
    .LOG2_N (LOG2_N),
    .DW     (DW)
  ) u_buf (
    .Clk   (Clk),
    .we    (in_hs),
    .waddr (wr_idx_q),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    sum_d    = sum_q;
    y_d      = y_q;
    ov_d     = ov_q;
    ol_d     = ol_q;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          sum_d    = sum_q + SW'(in_data);
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) state_d = MEAN;
        end
      end
      MEAN: begin
        state_d  = EMIT;
        y_d      = dev_ext;
        rd_idx_d = LOG2_N'(1);
        ov_d     = 1'b1;
        ol_d     = 1'b0;
      end
      EMIT: begin
        if (out_hs) begin
          if (ol_q) begin
            ov_d     = 1'b0;
            ol_d     = 1'b0;
            sum_d    = '0;
            wr_idx_d = '0;
            state_d  = LOAD;
          end else begin
            y_d      = y_q + dev_ext;
            rd_idx_d = rd_idx_q + 1'b1;
            ol_d     = (rd_idx_q == LAST_IDX);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      sum_q    <= '0;
      mean_q   <= '0;
      y_q      <= '0;
      ov_q     <= 1'b0;
      ol_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      sum_q    <= sum_d;
      mean_q   <= mean_d;
      y_q      <= y_d;
      ov_q     <= ov_d;
      ol_q     <= ol_d;
    end
  end

  assign out_valid = ov_q;
  assign out_last  = ol_q;
  assign out_data  = y_q;
  assign mean      = mean_q;

endmodule
`default_nettype wire

// File: tb/tb_price_profile.sv
`default_nettype none
// ============================================================================
// Module   : tb_price_profile
// Purpose  : Self-checking bench for price_profile (N=4 and N=256 instances).
// Revision : 1.0
// ============================================================================
module tb_price_profile;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        sel;

  logic        in_ready_2, ov2, ol2, busy2;
  logic [34:0] od2;
  logic [31:0] mean2;
  logic        in_ready_8, ov8, ol8, busy8;
  logic [40:0] od8;
  logic [31:0] mean8;

  logic        c_ir, c_ov, c_ol, c_busy;
  logic [31:0] c_mean;
  longint      c_od;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  price_profile #(.LOG2_N(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid & ~sel), .in_ready(in_ready_2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready & ~sel),
    .out_data(od2), .out_last(ol2), .mean(mean2), .busy(busy2)
  );

  price_profile #(.LOG2_N(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid & sel), .in_ready(in_ready_8),
    .in_data(in_data), .out_valid(ov8), .out_ready(out_ready & sel),
    .out_data(od8), .out_last(ol8), .mean(mean8), .busy(busy8)
  );

  always_comb begin
    c_ir   = sel ? in_ready_8 : in_ready_2;
    c_ov   = sel ? ov8 : ov2;
    c_ol   = sel ? ol8 : ol2;
    c_busy = sel ? busy8 : busy2;
    c_mean = sel ? mean8 : mean2;
    c_od   = sel ? longint'($signed(od8)) : longint'($signed(od2));
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] d, input int gap);
    int g = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge Clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    while (!c_ir && g < 20) begin @(posedge Clk); #1; g++; end
    if (g >= 20) chk("push_timeout", 0, 1);
    @(posedge Clk); #1;
    in_valid = 1'b0;
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0,..., 2 random ready
  task automatic run_window(input logic [31:0] xs[$], input int log2n, input int gapmax,
                            input int mode, input bit poke, input int stop, output longint ylast);
    longint ref_y[$];
    longint s = 0;
    longint m;
    longint y = 0;
    int     n = xs.size();
    int     k = 0;
    int     cyc = 0;
    bit     stalled = 1'b0;
    bit     r;
    longint pd = 0;
    logic   pl = 1'b0;
    ylast = -1;
    foreach (xs[i]) s += longint'(xs[i]);
    m = s >> log2n;
    foreach (xs[i]) begin
      y += longint'(xs[i]) - m;
      ref_y.push_back(y);
    end
    foreach (xs[i]) push(xs[i], (gapmax > 0) ? int'($urandom_range(1, gapmax)) : 0);
    chk("mean_cycle_busy", c_busy, 1);
    chk("mean_cycle_no_valid", c_ov, 0);
    @(posedge Clk); #1;
    chk("first_valid_latency", c_ov, 1);
    chk("mean", c_mean, m);
    while (k < stop && cyc < 2000) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      out_ready = r;
      if (poke) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        chk("emit_in_ready_low", c_ir, 0);
      end
      if (stalled) begin
        chk("hold_valid", c_ov, 1);
        chk("hold_data", c_od, pd);
        chk("hold_last", c_ol, pl);
      end
      if (c_ov && r) begin
        chk($sformatf("y%0d", k), c_od, ref_y[k]);
        chk($sformatf("last%0d", k), c_ol, (k == n - 1));
        ylast   = c_od;
        stalled = 1'b0;
        k++;
      end else begin
        stalled = c_ov;
        pd      = c_od;
        pl      = c_ol;
      end
      @(posedge Clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("handshake_count", k, stop);
    if (stop == n) begin
      chk("done_no_valid", c_ov, 0);
      chk("done_in_ready", c_ir, 1);
      chk("done_not_busy", c_busy, 0);
    end
  endtask

  logic [31:0] s1[$];
  logic [31:0] s2[$];
  logic [31:0] s5[$];
  logic [31:0] rq[$];
  longint      yl;

  initial begin
    Rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; sel = 1'b0;
    s1 = '{32'h10000, 32'h20000, 32'h30000, 32'h60000};
    s2 = '{32'd1, 32'd2, 32'd2, 32'd2};
    s5 = '{32'h50000, 32'h50000, 32'h50000, 32'h50000};
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_in_ready", c_ir, 0);
    chk("rst_out_valid", c_ov, 0);
    chk("rst_out_last", c_ol, 0);
    chk("rst_out_data", c_od, 0);
    chk("rst_mean", c_mean, 0);
    chk("rst_busy", c_busy, 0);
    Rst = 1'b1;
    #1;
    chk("post_rst_in_ready", c_ir, 1);

    run_window(s1, 2, 0, 0, 1'b0, 4, yl);
    run_window(s2, 2, 0, 0, 1'b0, 4, yl);
    chk("final_is_sum_mod_n", yl, 3);
    run_window(s1, 2, 0, 1, 1'b0, 4, yl);
    run_window(s1, 2, 3, 0, 1'b1, 4, yl);
    run_window(s1, 2, 0, 0, 1'b0, 4, yl);

    rq.delete();
    for (int i = 0; i < 4; i++) rq.push_back($urandom);
    run_window(rq, 2, 2, 2, 1'b0, 4, yl);

    run_window(s1, 2, 0, 0, 1'b0, 2, yl);
    Rst = 1'b0;
    #1;
    chk("midrst_out_valid", c_ov, 0);
    chk("midrst_in_ready", c_ir, 0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    #1;
    chk("midrst_rel_in_ready", c_ir, 1);
    chk("midrst_rel_mean", c_mean, 0);
    chk("midrst_rel_out_valid", c_ov, 0);
    chk("midrst_rel_busy", c_busy, 0);
    run_window(s5, 2, 0, 0, 1'b0, 4, yl);

    sel = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      rq.delete();
      for (int i = 0; i < 256; i++) rq.push_back($urandom);
      run_window(rq, 8, 0, (w == 0) ? 2 : 0, 1'b0, 256, yl);
      chk($sformatf("n256_ylast_range_w%0d", w), (yl >= 0 && yl < 256), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
